// File: rtl/ripple_counter.sv
// Synchronous up-counter built from one toggle flop per bit.
// Toggle enables ripple through an AND carry chain; every flop shares clk_in.
module ripple_counter #(
   parameter int WIDTH = 3
) (
   input  logic             clk_in,
   input  logic             reset_in,
   output logic [WIDTH-1:0] Q_out
);

   logic [WIDTH-1:0] toggle_en;

   // Stage 0 always toggles; stage i toggles once every lower stage is 1.
   assign toggle_en[0] = 1'b1;

   for (genvar i = 1; i < WIDTH; i++) begin : g_carry
      assign toggle_en[i] = toggle_en[i-1] & Q_out[i-1];
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         Q_out <= '0;
      end else begin
         Q_out <= Q_out ^ toggle_en;
      end
   end

endmodule

// File: tb/tb_ripple_counter.sv
// Directed bench for ripple_counter (WIDTH=3) with hand-computed expected counts.
module tb_ripple_counter;

   localparam int WIDTH = 3;

   logic             clk_in;
   logic             reset_in;
   logic [WIDTH-1:0] Q_out;

   int total = 0;
   int bad   = 0;

   ripple_counter #(.WIDTH(WIDTH)) dut (
      .clk_in   (clk_in),
      .reset_in (reset_in),
      .Q_out    (Q_out)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [WIDTH-1:0] got,
                        input logic [WIDTH-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One rising edge, then sample on the following falling edge.
   task automatic step_check(input string tag, input logic [WIDTH-1:0] exp);
      @(posedge clk_in);
      @(negedge clk_in);
      check(tag, Q_out, exp);
   endtask

   task automatic apply_reset_edge();
      reset_in = 1'b1;
      step_check("reset_edge", 3'd0);
      reset_in = 1'b0;
   endtask

   initial begin
      reset_in = 1'b1;
      @(negedge clk_in);

      // Reset covering one edge, then five counting edges.
      step_check("first_reset", 3'd0);
      reset_in = 1'b0;
      step_check("rel_1", 3'd1);
      step_check("rel_2", 3'd2);
      step_check("rel_3", 3'd3);
      step_check("rel_4", 3'd4);
      step_check("rel_5", 3'd5);

      // At 5: one-edge reset mid-count, then count resumes from 1.
      reset_in = 1'b1;
      step_check("mid_reset_at5", 3'd0);
      reset_in = 1'b0;
      step_check("after_mid_reset", 3'd1);

      // Free run through wrap-around.
      apply_reset_edge();
      for (int i = 1; i <= 7; i++) step_check("free_run", i[WIDTH-1:0]);
      step_check("wrap_to_0", 3'd0);
      step_check("wrap_then_1", 3'd1);

      // Reset exactly at all-ones must give 0, not a carry artifact.
      apply_reset_edge();
      for (int i = 1; i <= 7; i++) step_check("to_seven", i[WIDTH-1:0]);
      reset_in = 1'b1;
      step_check("reset_at7", 3'd0);
      reset_in = 1'b0;
      step_check("after_reset_at7", 3'd1);

      // Reset held high across four edges.
      reset_in = 1'b1;
      for (int i = 0; i < 4; i++) step_check("held_reset", 3'd0);
      reset_in = 1'b0;
      step_check("held_release", 3'd1);

      // Reset pulse lying entirely between edges is ignored.
      step_check("pre_pulse", 3'd2);
      #1 reset_in = 1'b1;
      #2 reset_in = 1'b0;
      check("pulse_no_async_clear", Q_out, 3'd2);
      step_check("post_pulse_1", 3'd3);
      step_check("post_pulse_2", 3'd4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
